// File: rtl/bram_wide2narrow_fifo.sv
// rtl/bram_wide2narrow_fifo.sv - buffered wide-to-narrow width converter for the BRAM read path
module bram_wide2narrow_fifo #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 32,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int SW    = (RATIO > 2) ? $clog2(RATIO) : 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

  logic [IN_W-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] slice_q, slice_d;

  logic            push;
  logic            beat;
  logic            word_done;
  logic [IN_W-1:0] rd_word;
  logic [OUT_W-1:0] sel_slice;

  // Readiness depends only on occupancy; a final-slice pop does not free the entry until the edge.
  assign s_ready   = ~rst & (count_q != FULL_CNT);
  assign m_valid   = (count_q != '0);
  assign m_last    = m_valid & (slice_q == LAST_SLICE);
  assign level     = count_q;

  assign push      = s_valid & s_ready;
  assign beat      = m_valid & m_ready;
  assign word_done = beat & (slice_q == LAST_SLICE);
  assign rd_word   = mem_q[rd_ptr_q];

  // Pick the current slice of the head word; slice order set by MSB_FIRST, zero when empty.
  always_comb begin
    sel_slice = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (slice_q == SW'(k)) begin
        if (MSB_FIRST != 0) begin
          sel_slice = rd_word[IN_W-1-k*OUT_W -: OUT_W];
        end else begin
          sel_slice = rd_word[k*OUT_W +: OUT_W];
        end
      end
    end
    m_data = m_valid ? sel_slice : '0;
  end

  // Next-state for pointers, occupancy and slice counter; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    slice_d  = slice_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      slice_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (beat) begin
        if (word_done) begin
          slice_d  = '0;
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
          slice_d  = slice_q + SW'(1);
        end
      end
      case ({push, word_done})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      slice_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      slice_q  <= slice_d;
    end
  end

  // Word storage is not reset; a flushed push is dropped so it never lands in memory.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_bram_wide2narrow_fifo.sv
// tb/tb_bram_wide2narrow_fifo.sv - scoreboard bench for bram_wide2narrow_fifo in both slice orders
module tb_bram_wide2narrow_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_ready_m, m_valid_m, m_last_m;
  logic [31:0] m_data_m;
  logic [2:0]  level_m;
  logic        s_ready_l, m_valid_l, m_last_l;
  logic [31:0] m_data_l;
  logic [2:0]  level_l;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_m [$];
  logic [31:0] exp_l [$];

  always #5 clk = ~clk;

  bram_wide2narrow_fifo #(.IN_W(64), .OUT_W(32), .DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_m),
    .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready), .m_last(m_last_m),
    .level(level_m)
  );

  bram_wide2narrow_fifo #(.IN_W(64), .OUT_W(32), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l),
    .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready), .m_last(m_last_l),
    .level(level_l)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int model_words();
    return (exp_m.size() + 1) / 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates expected slice queues from the bench's own view of occupancy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_m.delete();
      exp_l.delete();
    end else if (flush) begin
      exp_m.delete();
      exp_l.delete();
    end else begin
      bit full;
      bit pop;
      full = (model_words() == 4);
      pop  = (exp_m.size() != 0) && m_ready;
      if (pop) begin
        void'(exp_m.pop_front());
        void'(exp_l.pop_front());
      end
      if (s_valid && !full) begin
        exp_m.push_back(s_data[63:32]);
        exp_m.push_back(s_data[31:0]);
        exp_l.push_back(s_data[31:0]);
        exp_l.push_back(s_data[63:32]);
      end
    end
  end

  // Monitor: compares both DUTs against the head of the scoreboard away from the clock edge.
  always @(negedge clk) begin
    bit          ev;
    logic [31:0] em, el;
    bit          elast;
    ev    = (exp_m.size() != 0);
    em    = ev ? exp_m[0] : 32'h0;
    el    = ev ? exp_l[0] : 32'h0;
    elast = ev && (exp_m.size() % 2 == 1);
    chk("mon_m_valid_msb", m_valid_m, ev);
    chk("mon_m_valid_lsb", m_valid_l, ev);
    chk("mon_m_data_msb", m_data_m, em);
    chk("mon_m_data_lsb", m_data_l, el);
    chk("mon_m_last_msb", m_last_m, elast);
    chk("mon_m_last_lsb", m_last_l, elast);
    chk("mon_level_msb", level_m, model_words());
    chk("mon_level_lsb", level_l, model_words());
    chk("mon_s_ready_msb", s_ready_m, (!rst && model_words() != 4));
    chk("mon_s_ready_lsb", s_ready_l, (!rst && model_words() != 4));
  end

  initial begin
    // T1: reset state
    repeat (2) tick();
    @(negedge clk);
    chk("t1_s_ready_in_rst", s_ready_m, 1'b0);
    chk("t1_m_valid_in_rst", m_valid_m, 1'b0);
    chk("t1_m_data_in_rst", m_data_m, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_s_ready_after", s_ready_m, 1'b1);
    chk("t1_m_data_after", m_data_m, 32'h0);
    chk("t1_level_after", level_m, 3'd0);

    // T2/T3: single word, both slice orders
    s_data  = 64'h1122_3344_5566_7788;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t2_slice0", m_data_m, 32'h1122_3344);
    chk("t2_last0", m_last_m, 1'b0);
    chk("t3_slice0", m_data_l, 32'h5566_7788);
    tick();
    @(negedge clk);
    chk("t2_slice1", m_data_m, 32'h5566_7788);
    chk("t2_last1", m_last_m, 1'b1);
    chk("t3_slice1", m_data_l, 32'h1122_3344);
    chk("t3_last1", m_last_l, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_empty", m_valid_m, 1'b0);

    // T4: fill past full, drain, three rounds to wrap pointers
    for (int r = 0; r < 3; r++) begin
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        s_data  = {8'hA0 + 8'(r), 8'(i), 16'h1111, 8'hB0 + 8'(r), 8'(i), 16'h2222};
        s_valid = 1'b1;
        tick();
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk("t4_level_full", level_m, 3'd4);
      chk("t4_s_ready_full", s_ready_m, 1'b0);
      chk("t4_head", m_data_m, {8'hA0 + 8'(r), 8'h00, 16'h1111});
      m_ready = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("t4_drained", m_valid_m, 1'b0);
    end

    // T5: random backpressure, then pop-final while full
    for (int i = 0; i < 40; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      s_valid = 1'($urandom_range(0, 1));
      s_data  = {$urandom, $urandom};
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (10) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_data  = {32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)};
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    s_data  = 64'hEEEE_0001_FFFF_0001;
    s_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_level_after_pop", level_m, 3'd3);
    chk("t5_ready_after_pop", s_ready_m, 1'b1);
    m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t5_level_refill", level_m, 3'd4);
    m_ready = 1'b1;
    repeat (10) tick();

    // T6: flush after slice 0 of A, with a push pending
    s_data  = 64'hAAAA_0000_AAAA_1111;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_a_slice1", m_data_m, 32'hAAAA_1111);
    flush   = 1'b1;
    s_data  = 64'hCCCC_0000_CCCC_1111;
    s_valid = 1'b1;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("t6_level", level_m, 3'd0);
    chk("t6_m_valid", m_valid_m, 1'b0);
    s_data  = 64'hBBBB_0000_BBBB_1111;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t6_b_slice0", m_data_m, 32'hBBBB_0000);
    repeat (3) tick();

    // T1 again: asynchronous reset in the middle of traffic
    m_ready = 1'b0;
    s_data  = 64'h0123_4567_89AB_CDEF;
    s_valid = 1'b1;
    repeat (2) tick();
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_async_m_valid", m_valid_m, 1'b0);
    chk("t1_async_level", level_m, 3'd0);
    chk("t1_async_s_ready", s_ready_m, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rel_s_ready", s_ready_m, 1'b1);
    chk("t1_rel_m_data", m_data_m, 32'h0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
